// File: rtl/compressed_stream_framer_pkg.sv
// Shared types and constants for the compressed stream framer.
// Holds the state encoding, frame header constants and the checksum step.
package compressed_stream_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR0    = 3'd1,
        ST_HDR1    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_TRL0    = 3'd4,
        ST_TRL1    = 3'd5,
        ST_TRL2    = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    localparam logic [31:0] MAGIC_WORD      = 32'h4C5A4846;
    localparam logic [15:0] VERSION_ID      = 16'h0001;
    localparam int          SKID_DEPTH_DEF  = 2;

    // Rotate-left-by-one then XOR in the new payload word.
    function automatic logic [31:0] cksum_step(input logic [31:0] c, input logic [31:0] w);
        return {c[30:0], c[31]} ^ w;
    endfunction

endpackage

// File: rtl/compressed_stream_framer_skid_fifo.sv
// Purpose: 2-entry fall-through FIFO that absorbs encoder read latency and host stalls.
// Latency: 0 cycles (an arriving word is visible at the head the same cycle when empty).
// Backpressure: can_issue drops once entries plus in-flight reads, net of this cycle's pop, reach depth.
module frm_skid_fifo
    import compressed_stream_framer_pkg::*;
#(
    parameter int SKID_DEPTH = SKID_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        rd_issue,
    input  logic        in_vld,
    input  logic [31:0] in_dat,
    input  logic        pop,
    output logic        out_vld,
    output logic [31:0] out_dat,
    output logic        can_issue,
    output logic        inflight
);

    logic [31:0] mem_q [2];
    logic [31:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        inflight_q, inflight_d;
    logic        accept, bypass, wr, rd;
    logic [2:0]  occ;

    // Only words answering one of our own reads are taken in.
    assign accept    = in_vld && inflight_q;
    assign out_vld   = (cnt_q != 2'd0) || accept;
    assign out_dat   = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : in_dat;
    assign bypass    = accept && pop && (cnt_q == 2'd0);
    assign wr        = accept && !bypass;
    assign rd        = pop && (cnt_q != 2'd0);
    assign occ       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign can_issue = occ < 3'(SKID_DEPTH);
    assign inflight  = inflight_q;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = rd_issue;
        if (wr) begin
            mem_d[wr_ptr_q] = in_dat;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (rd) begin
            rd_ptr_d = !rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, wr} - {1'b0, rd};
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: rtl/compressed_stream_framer.sv
// Purpose: wraps encoder FIFO payload in a header/trailer frame on a valid/ready stream.
// Latency: registered output; payload word appears 2 cycles after its read enable.
// Backpressure: output held while !frm_ready; skid fills and enc_oen stops.
module compressed_stream_framer
    import compressed_stream_framer_pkg::*;
#(
    parameter logic [31:0] MAGIC      = MAGIC_WORD,
    parameter logic [15:0] VERSION    = VERSION_ID,
    parameter int          SKID_DEPTH = SKID_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        start_compress,
    input  logic        compress_done,
    input  logic [31:0] source_len,
    output logic        enc_oen,
    input  logic [31:0] enc_data,
    input  logic        enc_valid,
    input  logic        enc_empty,
    output logic [31:0] frm_data,
    output logic        frm_valid,
    input  logic        frm_ready,
    output logic        frm_last,
    output logic        frm_busy,
    output logic        frm_done,
    output logic [31:0] word_count,
    output logic [31:0] checksum
);

    state_t      state_q, state_d;
    logic [31:0] frm_data_q, frm_data_d;
    logic        frm_valid_q, frm_valid_d;
    logic        frm_last_q, frm_last_d;
    logic        frm_pay_q, frm_pay_d;
    logic [31:0] word_count_q, word_count_d;
    logic [31:0] checksum_q, checksum_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        xfer, out_free, drain_done;
    logic        sk_vld, sk_pop, sk_can_issue, sk_inflight;
    logic [31:0] sk_dat;

    assign xfer       = frm_valid_q && frm_ready;
    assign out_free   = !frm_valid_q || frm_ready;
    assign drain_done = compress_done && enc_empty && !sk_inflight && !sk_vld;
    assign enc_oen    = (state_q == ST_PAYLOAD) && !enc_empty && sk_can_issue;

    frm_skid_fifo #(.SKID_DEPTH(SKID_DEPTH)) u_skid (
        .clk       (clk),
        .rstN      (rstN),
        .rd_issue  (enc_oen),
        .in_vld    (enc_valid),
        .in_dat    (enc_data),
        .pop       (sk_pop),
        .out_vld   (sk_vld),
        .out_dat   (sk_dat),
        .can_issue (sk_can_issue),
        .inflight  (sk_inflight)
    );

    // HDR0/HDR1/PAYLOAD load the output register; TRL0..TRL2 name the word on the bus.
    always_comb begin
        state_d      = state_q;
        frm_data_d   = frm_data_q;
        frm_valid_d  = frm_valid_q && !frm_ready;
        frm_last_d   = frm_last_q && !xfer;
        frm_pay_d    = frm_pay_q && !xfer;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        busy_d       = busy_q;
        done_d       = done_q;
        sk_pop       = 1'b0;
        if (xfer && frm_pay_q) begin
            word_count_d = word_count_q + 32'd1;
            checksum_d   = cksum_step(checksum_q, frm_data_q);
        end
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_compress) begin
                    state_d      = ST_HDR0;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    word_count_d = '0;
                    checksum_d   = '0;
                end
            end
            ST_HDR0: begin
                if (out_free) begin
                    frm_data_d  = MAGIC;
                    frm_valid_d = 1'b1;
                    state_d     = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (out_free) begin
                    frm_data_d  = {VERSION, 16'h0000};
                    frm_valid_d = 1'b1;
                    state_d     = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (out_free) begin
                    if (sk_vld) begin
                        frm_data_d  = sk_dat;
                        frm_valid_d = 1'b1;
                        frm_pay_d   = 1'b1;
                        sk_pop      = 1'b1;
                    end else if (drain_done) begin
                        frm_data_d  = source_len;
                        frm_valid_d = 1'b1;
                        state_d     = ST_TRL0;
                    end
                end
            end
            ST_TRL0: begin
                if (xfer) begin
                    frm_data_d  = word_count_q;
                    frm_valid_d = 1'b1;
                    state_d     = ST_TRL1;
                end
            end
            ST_TRL1: begin
                if (xfer) begin
                    frm_data_d  = checksum_q;
                    frm_valid_d = 1'b1;
                    frm_last_d  = 1'b1;
                    state_d     = ST_TRL2;
                end
            end
            ST_TRL2: begin
                if (xfer) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= ST_IDLE;
            frm_data_q   <= '0;
            frm_valid_q  <= 1'b0;
            frm_last_q   <= 1'b0;
            frm_pay_q    <= 1'b0;
            word_count_q <= '0;
            checksum_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frm_data_q   <= frm_data_d;
            frm_valid_q  <= frm_valid_d;
            frm_last_q   <= frm_last_d;
            frm_pay_q    <= frm_pay_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign frm_data   = frm_data_q;
    assign frm_valid  = frm_valid_q;
    assign frm_last   = frm_last_q;
    assign frm_busy   = busy_q;
    assign frm_done   = done_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_compressed_stream_framer.sv
// Bench for compressed_stream_framer: directed frame table plus randomized frames
// checked against a queue-based model of the encoder FIFO and the frame format.
module tb_compressed_stream_framer;

    logic        clk;
    logic        rstN;
    logic        start_compress;
    logic        compress_done;
    logic [31:0] source_len;
    logic        enc_oen;
    logic [31:0] enc_data;
    logic        enc_valid;
    logic        enc_empty;
    logic [31:0] frm_data;
    logic        frm_valid;
    logic        frm_ready;
    logic        frm_last;
    logic        frm_busy;
    logic        frm_done;
    logic [31:0] word_count;
    logic [31:0] checksum;

    compressed_stream_framer dut (
        .clk            (clk),
        .rstN           (rstN),
        .start_compress (start_compress),
        .compress_done  (compress_done),
        .source_len     (source_len),
        .enc_oen        (enc_oen),
        .enc_data       (enc_data),
        .enc_valid      (enc_valid),
        .enc_empty      (enc_empty),
        .frm_data       (frm_data),
        .frm_valid      (frm_valid),
        .frm_ready      (frm_ready),
        .frm_last       (frm_last),
        .frm_busy       (frm_busy),
        .frm_done       (frm_done),
        .word_count     (word_count),
        .checksum       (checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int              n;
        logic [3:0][31:0] w;
        logic [31:0]     src;
        logic [31:0]     exp_cnt;
        logic [31:0]     exp_ck;
    } vec_t;

    int          checks;
    int          failures;
    logic [31:0] pay[$];
    logic [31:0] q[$];
    logic [31:0] got[$];
    bit          got_last[$];
    int          got_cyc[$];
    bit          pend;
    logic [31:0] pend_dat;
    int          ready_pct;
    bit          start_r;
    bit          cdone_r;
    int          issued;
    int          cyc;
    bit          stall_prev;
    logic [31:0] stall_dat;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_ck();
        logic [31:0] c = 32'h0;
        foreach (pay[i]) c = ((c << 1) | (c >> 31)) ^ pay[i];
        return c;
    endfunction

    task automatic fill(input int n);
        pay.delete();
        repeat (n) pay.push_back($urandom);
    endtask

    task automatic check_zero(input string tag);
        check32({tag, "_data"},  frm_data, 32'h0);
        check32({tag, "_valid"}, 32'(frm_valid), 32'h0);
        check32({tag, "_last"},  32'(frm_last), 32'h0);
        check32({tag, "_busy"},  32'(frm_busy), 32'h0);
        check32({tag, "_done"},  32'(frm_done), 32'h0);
        check32({tag, "_oen"},   32'(enc_oen), 32'h0);
        check32({tag, "_wc"},    word_count, 32'h0);
        check32({tag, "_ck"},    checksum, 32'h0);
    endtask

    // One clock: drive this cycle's inputs at negedge, then observe what the next edge will do.
    task automatic cycle();
        int delivered;
        @(negedge clk);
        enc_valid      = pend;
        enc_data       = pend ? pend_dat : 32'hDEADBEEF;
        pend           = 1'b0;
        enc_empty      = (q.size() == 0);
        frm_ready      = ($urandom_range(0, 99) < ready_pct);
        start_compress = start_r;
        compress_done  = cdone_r;
        #1;
        cyc++;
        if (stall_prev) begin
            check32("stall_valid", 32'(frm_valid), 32'h1);
            check32("stall_data", frm_data, stall_dat);
        end
        stall_prev = frm_valid && !frm_ready;
        stall_dat  = frm_data;
        if (frm_valid && frm_ready) begin
            got.push_back(frm_data);
            got_last.push_back(frm_last);
            got_cyc.push_back(cyc);
        end
        if (enc_oen) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL oen_when_empty actual=1 expected=0");
            end else begin
                pend     = 1'b1;
                pend_dat = q.pop_front();
                issued++;
            end
            delivered = (got.size() > 2) ? got.size() - 2 : 0;
            checks++;
            if (issued - delivered > 3) begin
                failures++;
                $display("FAIL overcommit actual=%0d expected<=3", issued - delivered);
            end
        end
    endtask

    task automatic run_frame(input int rpct, input bit trickle, input logic [31:0] src,
                             input int restart_at, input int reset_at);
        int  pushed;
        int  budget;
        bit  last_seen;
        bit  finished;
        q.delete();
        got.delete();
        got_last.delete();
        got_cyc.delete();
        issued     = 0;
        pushed     = 0;
        ready_pct  = rpct;
        source_len = src;
        if (!trickle) begin
            foreach (pay[i]) q.push_back(pay[i]);
            pushed = pay.size();
        end
        cdone_r = (pushed == pay.size());
        start_r = 1'b1;
        cycle();
        start_r   = 1'b0;
        last_seen = 1'b0;
        finished  = 1'b0;
        for (budget = 0; budget < 20000 && !finished; budget++) begin
            if (trickle && pushed < pay.size() && $urandom_range(0, 99) < 40) begin
                q.push_back(pay[pushed]);
                pushed++;
            end
            cdone_r = (pushed == pay.size());
            start_r = (restart_at >= 0) && (got.size() == restart_at + 2);
            cycle();
            if (budget == 1) check32("busy_in_frame", 32'(frm_busy), 32'h1);
            if (reset_at >= 0 && got.size() >= reset_at + 2) begin
                @(negedge clk);
                rstN = 1'b0;
                #1;
                check_zero("rst_mid");
                @(negedge clk);
                rstN       = 1'b1;
                stall_prev = 1'b0;
                start_r    = 1'b0;
                cdone_r    = 1'b0;
                q.delete();
                return;
            end
            if (last_seen) begin
                check32("done_after_last", 32'(frm_done), 32'h1);
                check32("busy_after_last", 32'(frm_busy), 32'h0);
                finished = 1'b1;
            end else if (got_last.size() > 0 && got_last[got_last.size() - 1]) begin
                last_seen = 1'b1;
            end
        end
        start_r = 1'b0;
        if (!finished) check32("frame_timeout", 32'h1, 32'h0);
    endtask

    task automatic check_frame(input logic [31:0] src, input logic [31:0] exp_cnt,
                               input logic [31:0] exp_ck);
        logic [31:0] exp[$];
        exp.push_back(32'h4C5A4846);
        exp.push_back(32'h00010000);
        foreach (pay[i]) exp.push_back(pay[i]);
        exp.push_back(src);
        exp.push_back(exp_cnt);
        exp.push_back(exp_ck);
        check32("frame_len", 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check32($sformatf("word%0d", i), got[i], exp[i]);
            check32($sformatf("last%0d", i), 32'(got_last[i]), 32'(i == exp.size() - 1));
        end
        check32("word_count_out", word_count, exp_cnt);
        check32("checksum_out", checksum, exp_ck);
    endtask

    vec_t tbl [5];

    initial begin
        checks = 0; failures = 0; cyc = 0; issued = 0;
        pend = 1'b0; pend_dat = 32'h0; stall_prev = 1'b0; stall_dat = 32'h0;
        start_r = 1'b0; cdone_r = 1'b0; ready_pct = 0;
        rstN = 1'b0; start_compress = 1'b0; compress_done = 1'b0; source_len = 32'h0;
        enc_data = 32'h0; enc_valid = 1'b0; enc_empty = 1'b1; frm_ready = 1'b0;

        tbl[0] = '{3, {32'h0, 32'h33333333, 32'h22222222, 32'h11111111}, 32'h40, 32'd3, 32'h33333333};
        tbl[1] = '{0, {32'h0, 32'h0, 32'h0, 32'h0}, 32'h13, 32'd0, 32'h0};
        tbl[2] = '{1, {32'h0, 32'h0, 32'h0, 32'h80000000}, 32'h14, 32'd1, 32'h80000000};
        tbl[3] = '{2, {32'h0, 32'h0, 32'h00000001, 32'h80000000}, 32'h25, 32'd2, 32'h0};
        tbl[4] = '{4, {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 32'h99, 32'd4, 32'h0};

        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < 5; i++) begin
            pay.delete();
            for (int j = 0; j < tbl[i].n; j++) pay.push_back(tbl[i].w[j]);
            run_frame(100, 1'b0, tbl[i].src, -1, -1);
            check_frame(tbl[i].src, tbl[i].exp_cnt, tbl[i].exp_ck);
        end

        fill(100);
        run_frame(30, 1'b1, 32'h1234, -1, -1);
        check_frame(32'h1234, 32'd100, model_ck());

        fill(100);
        run_frame(30, 1'b0, 32'h5678, -1, -1);
        check_frame(32'h5678, 32'd100, model_ck());

        fill(64);
        run_frame(100, 1'b0, 32'h0BAD, -1, -1);
        check_frame(32'h0BAD, 32'd64, model_ck());
        if (got_cyc.size() == 69) begin
            check32("payload_streak", 32'(got_cyc[65] - got_cyc[2]), 32'd63);
            check32("hdr_gap_ok", 32'(got_cyc[2] - got_cyc[1] <= 2), 32'h1);
            check32("trl_gap_ok", 32'(got_cyc[66] - got_cyc[65] <= 2), 32'h1);
        end else begin
            check32("tput_frame_len", 32'(got_cyc.size()), 32'd69);
        end

        fill(30);
        run_frame(70, 1'b0, 32'hAAAA, -1, 10);
        fill(7);
        run_frame(100, 1'b1, 32'h77, -1, -1);
        check_frame(32'h77, 32'd7, model_ck());

        fill(40);
        run_frame(60, 1'b1, 32'hC0DE, 5, -1);
        check_frame(32'hC0DE, 32'd40, model_ck());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
